dm_be_ctrl: RTL



---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_be_ctrl_if.sv | 24 ++
 rtl/dm_lane_align.sv | 45 ++++
 rtl/dm_be_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-enable data memory.
package dm_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_B:  mask = 4'b0001 << lane;
      SIZE_H:  mask = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dm_be_ctrl_if.sv
// MEM-stage access bus between the datapath and the data memory.
interface dm_be_ctrl_if;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        addr_err;
    logic        err_seen;

    modport master (
        output pc, addr, we, re, size, load_unsigned, wdata,
        input  rdata, busy, addr_err, err_seen
    );

    modport slave (
        input  pc, addr, we, re, size, load_unsigned, wdata,
        output rdata, busy, addr_err, err_seen
    );
endinterface

// File: rtl/dm_lane_align.sv
// Lane steering: extends sub-word loads and merges sub-word stores into the old word.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        loadUnsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    output logic [31:0] loadVal,
    output logic [31:0] mergedWord
);

    logic [31:0] wrep;
    logic [31:0] bitMask;
    logic [31:0] shifted;
    logic [15:0] half;

    always_comb begin
        // Replicate store data so any enabled lane picks up the right bytes.
        case (size)
            SIZE_B:  wrep = {4{wdata[7:0]}};
            SIZE_H:  wrep = {2{wdata[15:0]}};
            default: wrep = wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            bitMask[8*i +: 8] = {8{mask[i]}};
        end
        mergedWord = (wrep & bitMask) | (word & ~bitMask);
    end

    always_comb begin
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  loadVal = loadUnsigned ? {24'b0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  loadVal = loadUnsigned ? {16'b0, half} : {{16{half[15]}}, half};
            SIZE_W:  loadVal = word;
            default: loadVal = 32'b0;
        endcase
    end

endmodule

// File: rtl/dm_be_ctrl.sv
// Data memory with byte/half/word access, range/alignment checking and a
// post-reset clear engine; committed stores are logged to the console.
module dm_be_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic        clk,
    input logic        reset,
    dm_be_ctrl_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [32:0] SPAN  = 33'd4 << ADDR_W;

    logic [31:0] mem [DEPTH];

    state_t            state, stateNext;
    logic [ADDR_W-1:0] clrIdx, clrIdxNext;
    logic              errSeen, errSeenNext;

    logic [31:0]       offset;
    logic [ADDR_W-1:0] wordIdx;
    logic              access, sizeBad, misaligned, outOfRange, addrErr;
    logic              busy, storeEn;
    logic [3:0]        mask;
    logic [31:0]       oldWord, loadVal, mergedWord;

    always_comb begin
        offset     = bus.addr - BASE_ADDR;
        wordIdx    = offset[ADDR_W+1:2];
        access     = bus.we | bus.re;
        sizeBad    = (bus.size == 2'd3);
        misaligned = ((bus.size == SIZE_H) & bus.addr[0]) |
                     ((bus.size == SIZE_W) & (bus.addr[1:0] != 2'b00));
        outOfRange = (bus.addr < BASE_ADDR) | ({1'b0, offset} >= SPAN);
        addrErr    = access & (sizeBad | misaligned | outOfRange);
        busy       = (state == CLEAR);
        storeEn    = bus.we & !addrErr & !busy;
        mask       = byteEnable(bus.size, bus.addr[1:0]);
        oldWord    = mem[wordIdx];
    end

    dm_lane_align u_align (
        .size        (bus.size),
        .lane        (bus.addr[1:0]),
        .loadUnsigned(bus.load_unsigned),
        .word        (oldWord),
        .wdata       (bus.wdata),
        .mask        (mask),
        .loadVal     (loadVal),
        .mergedWord  (mergedWord)
    );

    assign bus.rdata    = (bus.re & !addrErr & !busy) ? loadVal : 32'b0;
    assign bus.busy     = busy;
    assign bus.addr_err = addrErr;
    assign bus.err_seen = errSeen;

    always_comb begin
        stateNext   = state;
        clrIdxNext  = clrIdx;
        errSeenNext = errSeen | (addrErr & !busy);
        case (state)
            CLEAR: begin
                clrIdxNext = clrIdx + 1'b1;
                if (clrIdx == {ADDR_W{1'b1}}) stateNext = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clrIdx  <= '0;
            errSeen <= 1'b0;
        end else begin
            state   <= stateNext;
            clrIdx  <= clrIdxNext;
            errSeen <= errSeenNext;
        end
    end

    // Array kept free of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clrIdx] <= 32'b0;
        end else if (storeEn) begin
            mem[wordIdx] <= mergedWord;
            $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, mergedWord);
        end
    end

endmodule
